// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the ULA operand loader.
//   estado_t   : loader FSM states (encoding is visible on the estado port)
//   LARGURA    : operand/result width
//   LARGURA_OP : op_sel width
//   MODO_BIT   : bit of the op word that selects logic mode
//   OP_*       : logic-mode operation encodings understood by the ULA
package ula_pkg;

  localparam int LARGURA    = 6;
  localparam int LARGURA_OP = 3;
  localparam int MODO_BIT   = 3;

  localparam logic [LARGURA_OP-1:0] OP_AND = 3'd0;
  localparam logic [LARGURA_OP-1:0] OP_OR  = 3'd1;
  localparam logic [LARGURA_OP-1:0] OP_XOR = 3'd2;
  localparam logic [LARGURA_OP-1:0] OP_NOT = 3'd3;

  typedef enum logic [2:0] {
    CARREGA_A  = 3'd0,
    CARREGA_B  = 3'd1,
    CARREGA_OP = 3'd2,
    EXECUTA    = 3'd3,
    MOSTRA     = 3'd4
  } estado_t;

endpackage

// File: rtl/detector_borda.sv
// detector_borda: 1-bit rising-edge detector.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_sinal      : level input (assumed synchronous)
//   o_borda      : high in the cycle i_sinal is 1 and was 0 at the previous edge
// RESET_VAL sets the remembered previous level after reset; using 1 means a
// level already high when reset is released is not reported as an edge.
module detector_borda #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sinal,
  output logic o_borda
);

  logic r_sinal_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sinal_d <= RESET_VAL;
    else          r_sinal_d <= i_sinal;
  end

  assign o_borda = i_sinal & ~r_sinal_d;

endmodule

// File: rtl/ula_carregador.sv
// ula_carregador: sequential operand loader and result capture for the ULA.
// Words arrive on the shared dado bus, one per rising edge of carregar, in the
// order A, B, op. The op word carries op_sel in [2:0] and modo in [3]. One cycle
// after the op load, the ULA's combinational result is registered for display.
//   clk, reset_n      : clock, asynchronous active-low reset
//   dado              : shared entry bus
//   carregar          : load button (level); its rising edge loads one word
//   cancela           : synchronous abort back to CARREGA_A, clears operands
//   A, B, modo, op_sel: registered drive to the ULA
//   O_ula, zero_ula   : ULA result return path
//   resultado,zero_out: registered result and zero flag
//   resultado_valido  : one-cycle pulse when resultado updates
//   ocupado           : high while an operation is in progress
//   estado            : current FSM state
module ula_carregador #(
  parameter int LARGURA    = 6,
  parameter int LARGURA_OP = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LARGURA-1:0]    dado,
  input  logic                  carregar,
  input  logic                  cancela,
  output logic [LARGURA-1:0]    A,
  output logic [LARGURA-1:0]    B,
  output logic                  modo,
  output logic [LARGURA_OP-1:0] op_sel,
  input  logic [LARGURA-1:0]    O_ula,
  input  logic                  zero_ula,
  output logic [LARGURA-1:0]    resultado,
  output logic                  zero_out,
  output logic                  resultado_valido,
  output logic                  ocupado,
  output logic [2:0]            estado
);

  import ula_pkg::*;

  estado_t               r_estado, w_prox;
  logic                  w_borda;
  logic                  w_ld_a, w_ld_b, w_ld_op, w_captura, w_limpa;
  logic [LARGURA-1:0]    r_a, r_b, r_resultado;
  logic                  r_modo, r_zero, r_valido;
  logic [LARGURA_OP-1:0] r_op_sel;

  detector_borda #(.RESET_VAL(1'b1)) u_borda (
    .clk     (clk),
    .reset_n (reset_n),
    .i_sinal (carregar),
    .o_borda (w_borda)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_estado <= CARREGA_A;
    else          r_estado <= w_prox;
  end

  // cancela outranks any load edge; EXECUTA ignores the edge and always
  // spends exactly one cycle so the ULA result has settled before capture.
  always_comb begin
    w_prox    = r_estado;
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_op   = 1'b0;
    w_captura = 1'b0;
    w_limpa   = 1'b0;
    if (cancela) begin
      w_limpa = 1'b1;
      w_prox  = CARREGA_A;
    end else begin
      case (r_estado)
        CARREGA_A: if (w_borda) begin
          w_ld_a = 1'b1;
          w_prox = CARREGA_B;
        end
        CARREGA_B: if (w_borda) begin
          w_ld_b = 1'b1;
          w_prox = CARREGA_OP;
        end
        CARREGA_OP: if (w_borda) begin
          w_ld_op = 1'b1;
          w_prox  = EXECUTA;
        end
        EXECUTA: begin
          w_captura = 1'b1;
          w_prox    = MOSTRA;
        end
        MOSTRA: if (w_borda) begin
          // chaining: a load edge here starts a new operation with A
          w_ld_a = 1'b1;
          w_prox = CARREGA_B;
        end
        default: w_prox = CARREGA_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_modo      <= 1'b0;
      r_op_sel    <= '0;
      r_resultado <= '0;
      r_zero      <= 1'b1;
      r_valido    <= 1'b0;
    end else begin
      r_valido <= w_captura;
      if (w_limpa) begin
        r_a      <= '0;
        r_b      <= '0;
        r_modo   <= 1'b0;
        r_op_sel <= '0;
      end else begin
        if (w_ld_a) r_a <= dado;
        if (w_ld_b) r_b <= dado;
        if (w_ld_op) begin
          r_op_sel <= dado[LARGURA_OP-1:0];
          r_modo   <= dado[MODO_BIT];
        end
      end
      // resultado/zero_out survive cancela; only an EXECUTA cycle updates them
      if (w_captura) begin
        r_resultado <= O_ula;
        r_zero      <= zero_ula;
      end
    end
  end

  assign A                = r_a;
  assign B                = r_b;
  assign modo             = r_modo;
  assign op_sel           = r_op_sel;
  assign resultado        = r_resultado;
  assign zero_out         = r_zero;
  assign resultado_valido = r_valido;
  assign estado           = r_estado;
  assign ocupado          = (r_estado == CARREGA_B) || (r_estado == CARREGA_OP) ||
                            (r_estado == EXECUTA);

endmodule

// File: tb/tb_ula_carregador.sv
module tb_ula_carregador;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] dado = '0;
  logic       carregar = 1'b1;
  logic       cancela = 1'b0;
  logic [5:0] A, B, O_ula, resultado;
  logic       modo, zero_ula, zero_out, resultado_valido, ocupado;
  logic [2:0] op_sel, estado;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  ula_carregador dut (
    .clk(clk), .reset_n(reset_n), .dado(dado), .carregar(carregar),
    .cancela(cancela), .A(A), .B(B), .modo(modo), .op_sel(op_sel),
    .O_ula(O_ula), .zero_ula(zero_ula), .resultado(resultado),
    .zero_out(zero_out), .resultado_valido(resultado_valido),
    .ocupado(ocupado), .estado(estado)
  );

  // Downstream ULA stand-in: logic mode AND/OR/XOR/NOT, arithmetic mode
  // ADD/SUB/INC/DEC, anything else passes A. Zero flag is result==0.
  function automatic logic [5:0] ula_ref(input logic [5:0] a, input logic [5:0] b,
                                         input logic m, input logic [2:0] op);
    logic [5:0] r;
    if (m) begin
      case (op)
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a ^ b;
        3'd3: r = ~a;
        default: r = a;
      endcase
    end else begin
      case (op)
        3'd0: r = a + b;
        3'd1: r = a - b;
        3'd2: r = a + 6'd1;
        3'd3: r = a - 6'd1;
        default: r = a;
      endcase
    end
    return r;
  endfunction

  assign O_ula    = ula_ref(A, B, modo, op_sel);
  assign zero_ula = (O_ula == 6'd0);

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nome, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic carrega(input logic [5:0] d);
    dado = d;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
    tick();
  endtask

  // Reference model: counts how many words of the current operation have been
  // taken (0..2), then one execute cycle (3), then showing the result (4).
  int         m_fase;
  logic [5:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic       m_modo, m_zero, m_valid, m_prev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fase = 0; m_a = 0; m_b = 0; m_op = 0; m_modo = 0;
      m_res = 0; m_zero = 1; m_valid = 0; m_prev = 1;
    end else begin
      logic pressed;
      pressed = carregar && !m_prev;
      m_prev  = carregar;
      m_valid = 0;
      if (cancela) begin
        m_fase = 0; m_a = 0; m_b = 0; m_op = 0; m_modo = 0;
      end else if (m_fase == 3) begin
        m_res   = ula_ref(m_a, m_b, m_modo, m_op);
        m_zero  = (m_res == 0);
        m_valid = 1;
        m_fase  = 4;
      end else if (pressed) begin
        if (m_fase == 0 || m_fase == 4) begin m_a = dado; m_fase = 1; end
        else if (m_fase == 1) begin m_b = dado; m_fase = 2; end
        else begin m_op = dado[2:0]; m_modo = dado[3]; m_fase = 3; end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_estado", estado, m_fase);
      chk("mon_A", A, m_a);
      chk("mon_B", B, m_b);
      chk("mon_op_sel", op_sel, m_op);
      chk("mon_modo", modo, m_modo);
      chk("mon_resultado", resultado, m_res);
      chk("mon_zero_out", zero_out, m_zero);
      chk("mon_valido", resultado_valido, m_valid);
      chk("mon_ocupado", ocupado, (m_fase >= 1 && m_fase <= 3));
    end
  end

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] op;
    logic [5:0] res;
    logic       zero;
  } vet_t;

  vet_t tab[7];

  initial begin
    logic [5:0] held;
    tab[0] = '{6'b101100, 6'b011010, 6'b001000, 6'b001000, 1'b0}; // AND
    tab[1] = '{6'b111111, 6'b010101, 6'b001011, 6'b000000, 1'b1}; // NOT
    tab[2] = '{6'b111111, 6'b111111, 6'b000001, 6'b000000, 1'b1}; // SUB, modo 0
    tab[3] = '{6'b101010, 6'b010101, 6'b001001, 6'b111111, 1'b0}; // OR
    tab[4] = '{6'b110000, 6'b101000, 6'b001010, 6'b011000, 1'b0}; // XOR
    tab[5] = '{6'b000011, 6'b000101, 6'b110000, 6'b001000, 1'b0}; // ADD, [5:4] ignored
    tab[6] = '{6'b111111, 6'b000001, 6'b000000, 6'b000000, 1'b1}; // ADD wraps

    // reset with the button held high
    repeat (3) tick();
    chk("rst_estado", estado, 0);
    chk("rst_zero_out", zero_out, 1);
    chk("rst_resultado", resultado, 0);
    chk("rst_valido", resultado_valido, 0);
    chk("rst_ocupado", ocupado, 0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    chk("held_after_rst_estado", estado, 0);
    chk("held_after_rst_A", A, 0);
    carregar = 1'b0;
    tick();
    carrega(6'b010101);
    chk("first_edge_A", A, 6'b010101);
    chk("first_edge_estado", estado, 1);
    cancela = 1'b1; tick(); cancela = 1'b0;
    chk("cancel_B_estado", estado, 0);
    chk("cancel_B_A", A, 0);

    // held button: exactly one capture
    dado = 6'b110011;
    carregar = 1'b1;
    repeat (10) tick();
    carregar = 1'b0;
    tick();
    chk("hold_A", A, 6'b110011);
    chk("hold_estado", estado, 1);
    cancela = 1'b1; tick(); cancela = 1'b0;

    // table of complete operations, chained from MOSTRA after the first
    for (int i = 0; i < 7; i++) begin
      carrega(tab[i].a);
      carrega(tab[i].b);
      carrega(tab[i].op);
      chk($sformatf("vec%0d_resultado", i), resultado, tab[i].res);
      chk($sformatf("vec%0d_zero_out", i), zero_out, tab[i].zero);
      chk($sformatf("vec%0d_valido", i), resultado_valido, 1);
      chk($sformatf("vec%0d_estado", i), estado, 4);
      chk($sformatf("vec%0d_op_sel", i), op_sel, {29'd0, tab[i].op[2:0]});
      chk($sformatf("vec%0d_modo", i), modo, tab[i].op[3]);
      tick();
      chk($sformatf("vec%0d_pulse_drop", i), resultado_valido, 0);
      chk($sformatf("vec%0d_hold_estado", i), estado, 4);
      chk($sformatf("vec%0d_hold_res", i), resultado, tab[i].res);
    end
    held = tab[6].res;

    // load edge in MOSTRA chains a new A
    carrega(6'b000111);
    chk("mostra_A", A, 6'b000111);
    chk("mostra_estado", estado, 1);
    chk("mostra_res_held", resultado, held);

    // cancela together with the op-load edge
    carrega(6'b001100);
    chk("pre_cancel_estado", estado, 2);
    dado = 6'b001001;
    carregar = 1'b1;
    cancela = 1'b1;
    tick();
    cancela = 1'b0;
    carregar = 1'b0;
    chk("cancel_op_estado", estado, 0);
    chk("cancel_op_A", A, 0);
    chk("cancel_op_B", B, 0);
    chk("cancel_op_op_sel", op_sel, 0);
    chk("cancel_op_modo", modo, 0);
    chk("cancel_op_res", resultado, held);
    chk("cancel_op_valido", resultado_valido, 0);
    tick();
    chk("cancel_op_valido2", resultado_valido, 0);
    chk("cancel_op_estado2", estado, 0);

    // reset while in EXECUTA: nothing captured
    carrega(6'b101100);
    carrega(6'b011010);
    dado = 6'b001001;
    carregar = 1'b1;
    tick();
    chk("exec_estado", estado, 3);
    chk("exec_ocupado", ocupado, 1);
    carregar = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_exec_estado", estado, 0);
    chk("rst_exec_A", A, 0);
    chk("rst_exec_B", B, 0);
    chk("rst_exec_resultado", resultado, 0);
    chk("rst_exec_zero_out", zero_out, 1);
    chk("rst_exec_valido", resultado_valido, 0);
    tick();
    chk("rst_exec_valido2", resultado_valido, 0);
    chk("rst_exec_resultado2", resultado, 0);
    reset_n = 1'b1;
    tick();

    // random stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 6) carregar = $urandom_range(0, 1);
      dado = 6'($urandom);
      cancela = ($urandom_range(0, 39) == 0);
      tick();
    end
    cancela = 1'b0;
    carregar = 1'b0;
    tick();
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
